// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC unit.
// Exception support is compiled in with NPC_EXC_EN.
package npc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6
  } br_type_e;

  typedef enum logic [1:0] {
    J_NONE = 2'd0,
    J_J    = 2'd1,
    J_JAL  = 2'd2,
    J_JR   = 2'd3
  } j_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

  function automatic logic [31:0] sext_imm16_sh2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_br_cmp.sv
// Branch condition evaluation on forwarded rs/rt; all compares signed 32-bit.
module npc_br_cmp
  import npc_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        cond
);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = (rs == rt);
      BR_BNE:  cond = (rs != rt);
      BR_BLEZ: cond = rs[31] | ~(|rs);
      BR_BGTZ: cond = ~rs[31] & (|rs);
      BR_BLTZ: cond = rs[31];
      BR_BGEZ: cond = ~rs[31];
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// Fetch PC register with in-ID branch/jump resolution and stall-tolerant redirect hold.
// Optional exception/eret path (EPC register, exc_i/eret_i/epc_o) enabled by NPC_EXC_EN.
module npc_unit
  import npc_pkg::*;
#(
  parameter int unsigned         PC_W     = 32,
  parameter logic [PC_W-1:0]     RESET_PC = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0]     EXC_PC   = PC_W'(DEF_EXC_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic [31:0]     id_instr_i,
  input  logic [2:0]      br_type_i,
  input  logic [1:0]      j_sel_i,
  input  logic [31:0]     rs_val_i,
  input  logic [31:0]     rt_val_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc4_o,
  output logic [PC_W-1:0] link_o,
  output logic            taken_o,
  output logic            hold_o
`ifdef NPC_EXC_EN
  ,
  input  logic            exc_i,
  input  logic            eret_i,
  output logic [PC_W-1:0] epc_o
`endif
);

  state_e          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] held_tgt;
  logic [PC_W-1:0] id_pc4;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] target;
  logic            br_cond;
  logic            unused_bits;

  npc_br_cmp u_br_cmp (
    .br_type (br_type_i),
    .rs      (rs_val_i),
    .rt      (rt_val_i),
    .cond    (br_cond)
  );

  assign id_pc4 = id_pc_i + PC_W'(4);
  assign br_tgt = id_pc4 + PC_W'($signed(sext_imm16_sh2(id_instr_i[15:0])));
  assign j_tgt  = {id_pc4[PC_W-1:28], id_instr_i[25:0], 2'b00};

  // A jump overrides any simultaneous branch request.
  always_comb begin
    target = br_tgt;
    case (j_sel_i)
      J_J, J_JAL: target = j_tgt;
      J_JR:       target = PC_W'(rs_val_i);
      default:    target = br_tgt;
    endcase
  end

  assign taken_o     = br_cond | (j_sel_i != J_NONE);
  assign link_o      = id_pc_i + PC_W'(8);
  assign pc_o        = pc;
  assign pc4_o       = pc + PC_W'(4);
  assign hold_o      = (state == HOLD);
  assign unused_bits = ^{id_instr_i[31:26], EXC_PC};

`ifdef NPC_EXC_EN
  logic [PC_W-1:0] epc;
  assign epc_o = epc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      state    <= RUN;
      held_tgt <= '0;
`ifdef NPC_EXC_EN
      epc      <= '0;
`endif
    end else begin
`ifdef NPC_EXC_EN
      if (exc_i) begin
        pc       <= EXC_PC;
        epc      <= id_pc_i;
        state    <= RUN;
        held_tgt <= '0;
      end else if (eret_i) begin
        pc       <= epc;
        state    <= RUN;
        held_tgt <= '0;
      end else
`endif
      begin
        case (state)
          RUN: begin
            if (taken_o && stall_i) begin
              held_tgt <= target;
              state    <= HOLD;
            end else if (taken_o) begin
              pc <= target;
            end else if (!stall_i) begin
              pc <= pc + PC_W'(4);
            end
          end
          HOLD: begin
            // ID is frozen on the redirecting instruction, so its taken_o is stale here.
            if (!stall_i) begin
              pc       <= held_tgt;
              held_tgt <= '0;
              state    <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: directed vector table, hold/reset sequences, random vs. model.
// Exception checks are included when NPC_EXC_EN is defined.
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] id_pc = '0;
  logic [31:0] instr = '0;
  logic [2:0]  br = '0;
  logic [1:0]  js = '0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] pc_o, pc4_o, link_o;
  logic        taken_o, hold_o;
`ifdef NPC_EXC_EN
  logic        exc = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc_o;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  npc_unit #(.PC_W(32), .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall),
    .id_pc_i    (id_pc),
    .id_instr_i (instr),
    .br_type_i  (br),
    .j_sel_i    (js),
    .rs_val_i   (rs),
    .rt_val_i   (rt),
    .pc_o       (pc_o),
    .pc4_o      (pc4_o),
    .link_o     (link_o),
    .taken_o    (taken_o),
    .hold_o     (hold_o)
`ifdef NPC_EXC_EN
    ,
    .exc_i      (exc),
    .eret_i     (eret),
    .epc_o      (epc_o)
`endif
  );

  typedef struct {
    logic        stall;
    logic [31:0] id_pc;
    logic [31:0] instr;
    logic [2:0]  br;
    logic [1:0]  js;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are already applied; check combinational outputs, clock once, check registered ones.
  task automatic cycle(input logic exp_taken, input logic [31:0] exp_link,
                       input logic [31:0] exp_pc, input logic exp_hold);
    #1;
    chk("taken_o", {31'b0, taken_o}, {31'b0, exp_taken});
    chk("link_o", link_o, exp_link);
    @(posedge clk);
    #1;
    chk("pc_o", pc_o, exp_pc);
    chk("pc4_o", pc4_o, exp_pc + 32'd4);
    chk("hold_o", {31'b0, hold_o}, {31'b0, exp_hold});
  endtask

  // Reference model: architectural rules expressed with signed integer arithmetic.
  function automatic logic m_cond(input logic [2:0] b, input logic [31:0] a, input logic [31:0] c);
    int sa, sc;
    sa = int'(a);
    sc = int'(c);
    case (b)
      3'd1: return sa == sc;
      3'd2: return sa != sc;
      3'd3: return sa <= 0;
      3'd4: return sa > 0;
      3'd5: return sa < 0;
      3'd6: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [1:0] j, input logic [31:0] r);
    int off;
    logic [31:0] idx;
    if (j == 2'd3) return r;
    if (j != 2'd0) begin
      idx = {6'b0, ins[25:0]};
      return ((p + 32'd4) & 32'hF000_0000) | (idx * 4);
    end
    off = int'($signed(ins[15:0]));
    return p + 32'd4 + 32'(off * 4);
  endfunction

  logic [31:0] m_pc, m_tgt, m_epc;
  logic        m_hold;

  task automatic set_in(input logic s, input logic [31:0] p, input logic [31:0] ins,
                        input logic [2:0] b, input logic [1:0] j,
                        input logic [31:0] a, input logic [31:0] c);
    stall = s; id_pc = p; instr = ins; br = b; js = j; rs = a; rt = c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic        t, do_exc, do_eret;
    logic [31:0] tg;

    tbl[0]  = '{1'b0, 32'h0000_3010, 32'h0000_FFFE, 3'd0, 2'd0, 32'd5, 32'd5, 1'b0, 32'h0000_3004};
    tbl[1]  = '{1'b0, 32'h0000_3010, 32'h0000_FFFE, 3'd0, 2'd0, 32'd5, 32'd5, 1'b0, 32'h0000_3008};
    tbl[2]  = '{1'b0, 32'h0000_3010, 32'h0000_FFFE, 3'd1, 2'd0, 32'd5, 32'd5, 1'b1, 32'h0000_300C};
    tbl[3]  = '{1'b0, 32'h0000_3010, 32'h0000_FFFE, 3'd2, 2'd0, 32'd5, 32'd5, 1'b0, 32'h0000_3010};
    tbl[4]  = '{1'b0, 32'h0000_3010, 32'h0000_FFFE, 3'd6, 2'd0, 32'h8000_0000, 32'd0, 1'b0, 32'h0000_3014};
    tbl[5]  = '{1'b0, 32'h0000_3010, 32'h0000_FFFE, 3'd5, 2'd0, 32'h8000_0000, 32'd0, 1'b1, 32'h0000_300C};
    tbl[6]  = '{1'b0, 32'h0000_3010, 32'h0000_FFFE, 3'd4, 2'd0, 32'd0, 32'd0, 1'b0, 32'h0000_3010};
    tbl[7]  = '{1'b0, 32'h0000_3010, 32'h0000_000C, 3'd3, 2'd0, 32'd0, 32'd0, 1'b1, 32'h0000_3044};
    tbl[8]  = '{1'b0, 32'h3000_1000, 32'h0800_0100, 3'd0, 2'd1, 32'd0, 32'd0, 1'b1, 32'h3000_0400};
    tbl[9]  = '{1'b0, 32'h3000_1000, 32'h0C00_0100, 3'd0, 2'd2, 32'd0, 32'd0, 1'b1, 32'h3000_0400};
    tbl[10] = '{1'b0, 32'h3000_1000, 32'h0000_0010, 3'd1, 2'd3, 32'h3400, 32'h3400, 1'b1, 32'h0000_3400};
    tbl[11] = '{1'b0, 32'h0000_3100, 32'h0000_0010, 3'd7, 2'd0, 32'd1, 32'd1, 1'b0, 32'h0000_3404};
    tbl[12] = '{1'b1, 32'h0000_3100, 32'h0000_0010, 3'd0, 2'd0, 32'd1, 32'd1, 1'b0, 32'h0000_3404};
    tbl[13] = '{1'b0, 32'h0000_3100, 32'h0000_0000, 3'd0, 2'd3, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'hFFFF_FFFC};
    tbl[14] = '{1'b0, 32'h0000_3100, 32'h0000_0000, 3'd0, 2'd0, 32'd0, 32'd1, 1'b0, 32'h0000_0000};
    tbl[15] = '{1'b0, 32'hFFFF_FFF8, 32'h0000_0002, 3'd1, 2'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0004};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc_o", pc_o, 32'h0000_3000);
    chk("reset hold_o", {31'b0, hold_o}, 32'd0);
`ifdef NPC_EXC_EN
    chk("reset epc_o", epc_o, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].stall, tbl[i].id_pc, tbl[i].instr, tbl[i].br, tbl[i].js, tbl[i].rs, tbl[i].rt);
      cycle(tbl[i].exp_taken, tbl[i].id_pc + 32'd8, tbl[i].exp_pc, 1'b0);
    end

    // Redirect under stall is held, then released; a new redirect at release is ignored.
    set_in(1'b1, 32'h0000_3030, 32'h0000_0003, 3'd1, 2'd0, 32'd7, 32'd7);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_3038, 32'h0000_0004, 1'b1);
    set_in(1'b0, 32'h0000_3030, 32'h0000_0003, 3'd0, 2'd3, 32'h5000, 32'd0);
    cycle(1'b1, 32'h0000_3038, 32'h0000_3040, 1'b0);
    set_in(1'b0, 32'h0000_3030, 32'h0000_0003, 3'd0, 2'd0, 32'd0, 32'd1);
    cycle(1'b0, 32'h0000_3038, 32'h0000_3044, 1'b0);

    // Reset in HOLD discards the held target.
    set_in(1'b1, 32'h0000_3030, 32'h0000_0003, 3'd1, 2'd0, 32'd7, 32'd7);
    cycle(1'b1, 32'h0000_3038, 32'h0000_3044, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid-hold reset pc_o", pc_o, 32'h0000_3000);
    chk("mid-hold reset hold_o", {31'b0, hold_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 32'h0000_3030, 32'h0000_0003, 3'd0, 2'd0, 32'd0, 32'd1);
    cycle(1'b0, 32'h0000_3038, 32'h0000_3004, 1'b0);

`ifdef NPC_EXC_EN
    set_in(1'b1, 32'h0000_3030, 32'h0000_0003, 3'd1, 2'd0, 32'd7, 32'd7);
    cycle(1'b1, 32'h0000_3038, 32'h0000_3004, 1'b1);
    set_in(1'b1, 32'h0000_3020, 32'h0000_0000, 3'd0, 2'd0, 32'd0, 32'd1);
    exc = 1'b1;
    cycle(1'b0, 32'h0000_3028, 32'h0000_4180, 1'b0);
    chk("exc epc_o", epc_o, 32'h0000_3020);
    exc = 1'b0;
    stall = 1'b0;
    cycle(1'b0, 32'h0000_3028, 32'h0000_4184, 1'b0);
    eret = 1'b1;
    stall = 1'b1;
    cycle(1'b0, 32'h0000_3028, 32'h0000_3020, 1'b0);
    exc = 1'b1;
    id_pc = 32'h0000_3050;
    cycle(1'b0, 32'h0000_3058, 32'h0000_4180, 1'b0);
    chk("exc+eret epc_o", epc_o, 32'h0000_3050);
    exc = 1'b0;
    eret = 1'b0;
`endif

    // Random stimulus against the reference model, from a fresh reset.
    rst_n = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 3'd0, 2'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = 32'h0000_3000;
    m_hold = 1'b0;
    m_tgt = '0;
    m_epc = '0;
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 9) < 3);
      id_pc = {$urandom_range(0, 3) == 0 ? 4'hF : 4'h0, 26'($urandom), 2'b00};
      instr = $urandom;
      br = 3'($urandom_range(0, 7));
      js = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = 32'h8000_0000;
        default: rs = $urandom;
      endcase
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      do_exc = 1'b0;
      do_eret = 1'b0;
`ifdef NPC_EXC_EN
      do_exc = ($urandom_range(0, 29) == 0);
      do_eret = ($urandom_range(0, 19) == 0);
      exc = do_exc;
      eret = do_eret;
`endif
      t = m_cond(br, rs, rt) || (js != 2'd0);
      tg = m_target(id_pc, instr, js, rs);
      if (do_exc) begin
        m_pc = 32'h0000_4180; m_epc = id_pc; m_hold = 1'b0;
      end else if (do_eret) begin
        m_pc = m_epc; m_hold = 1'b0;
      end else if (m_hold) begin
        if (!stall) begin m_pc = m_tgt; m_hold = 1'b0; end
      end else if (t && stall) begin
        m_hold = 1'b1; m_tgt = tg;
      end else if (t) begin
        m_pc = tg;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
      cycle(t, id_pc + 32'd8, m_pc, m_hold);
`ifdef NPC_EXC_EN
      chk("rand epc_o", epc_o, m_epc);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
Parametrised next-PC generator that owns the fetch PC register. It resolves branch conditions itself from register operands, supporting six compare modes. It also computes j/jal/jr targets and holds a pending redirect across pipeline stalls. It sits between IF and ID: it drives the instruction-memory address and takes redirect requests from the decode stage. MIPS delay-slot semantics apply, so there is no flush output.

Parameters:
PC_W, 32, PC/address width (≥ 28+2)
RESET_PC, 32'h0000_3000, PC value after reset
EXC_PC, 32'h0000_4180, exception vector (used only with NPC_EXC_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  freeze PC (IF/ID stall)
id_pc_i  in  PC_W  PC of instruction in ID
id_instr_i  in  32  instruction in ID (imm16 = [15:0], index = [25:0])
br_type_i  in  3  branch mode (package enum)
j_sel_i  in  2  00 none, 01 j, 10 jal, 11 jr
rs_val_i  in  32  forwarded rs value (compare operand; jr target)
rt_val_i  in  32  forwarded rt value (compare operand)
pc_o  out  PC_W  current fetch PC
pc4_o  out  PC_W  pc_o+4
link_o  out  PC_W  id_pc_i+8 (jal link value)
taken_o  out  1  ID redirect taken this cycle (combinational)
hold_o  out  1  redirect pending in HOLD state

Behaviour:
- Reset: pc_o=RESET_PC, state=RUN, held target=0, hold_o=0.
- br_type values: NONE=0, BEQ=1 (rs==rt), BNE=2 (rs!=rt), BLEZ=3 (rs<=0), BGTZ=4 (rs>0), BLTZ=5 (rs<0), BGEZ=6 (rs>=0). All compares are signed 32-bit; value 7 is treated as NONE.
- Branch target: id_pc_i+4 + (sext(imm16)<<2), computed modulo 2^PC_W.
- J/JAL target: {(id_pc_i+4)[PC_W-1:28], index, 2'b00}.
- JR target: rs_val_i[PC_W-1:0]; low 2 bits are passed through unchanged.
- taken_o = (branch condition true) | (j_sel_i != 0). If both br_type_i and j_sel_i are nonzero, the jump wins.
- FSM RUN:
  - taken & !stall: pc <= target.
  - taken & stall: latch target, go to HOLD, pc held.
  - !taken & !stall: pc <= pc+4.
  - stall: pc held.
- FSM HOLD (hold_o=1):
  - stall: pc held; taken_o is ignored because ID is frozen on the same instruction.
  - !stall: pc <= held target, return to RUN.
- Priority: reset > exception (with feature) > HOLD release > new redirect > sequential.
- One cycle latency from redirect to pc_o update. pc_o is purely registered.
- Wrap-around: pc+4 at the top of the PC_W space wraps to 0 with no error.
- Reset asserted in HOLD: the held target is discarded and state returns to RUN.

Optional Feature:
NPC_EXC_EN
- With the macro: adds ports exc_i (in 1), eret_i (in 1), epc_o (out PC_W), and an EPC register that resets to 0.
  - exc_i: pc <= EXC_PC and epc <= id_pc_i, regardless of stall. The HOLD target is cleared and state goes to RUN.
  - eret_i (when exc_i=0): pc <= epc, regardless of stall, clearing HOLD.
  - exc_i and eret_i together: exc wins.
- Without the macro: these ports and the EPC register do not exist, and priority reduces to the base list.

Decomposition:
- Package npc_pkg holds:
  - br_type_e enum (3 bits) and j_sel_e enum (2 bits).
  - state_e {RUN, HOLD}.
  - Default RESET_PC and EXC_PC constants.
  - Function sext_imm16_sh2.
- One sub-module, npc_br_cmp: purely combinational. Inputs are br_type, rs and rt; output is cond.

Test Plan:
1. Reset release with stall_i=0 for 3 cycles -> pc_o = 0x3000, 0x3004, 0x3008.
2. id_pc=0x3010, BEQ, rs=rt=5, imm=0xFFFE, no stall -> taken_o=1; next pc_o = 0x300C. Repeat with BNE -> pc_o = pc+4.
3. BGEZ rs=0x8000_0000 -> not taken. BLTZ with the same rs -> taken. BGTZ rs=0 -> not taken. BLEZ rs=0 -> taken.
4. id_pc=0x3000_1000, J index=0x0000_100 -> target 0x3000_0400. jal -> link_o = 0x3000_1008. jr rs=0x3400 with simultaneous BEQ true -> pc_o = 0x3400.
5. Taken branch (target 0x3040) while stall_i=1 for 3 cycles -> hold_o=1 and pc_o unchanged during the stall. The cycle after stall drops, pc_o = 0x3040 and hold_o=0. Reset asserted mid-HOLD -> pc_o = 0x3000, hold_o=0.
6. (NPC_EXC_EN) exc_i during stall with id_pc=0x3020 -> pc_o = 0x4180, epc_o = 0x3020, HOLD cleared. Later eret_i -> pc_o = 0x3020. exc_i and eret_i together -> pc_o = 0x4180.
